// File: rtl/bidir_bus_pkg.sv
// Shared types and width helpers for the bidirectional bus port.
package bidir_bus_pkg;

    typedef enum logic [1:0] {
        LISTEN  = 2'd0,
        TURN_TX = 2'd1,
        DRIVE   = 2'd2,
        TURN_RX = 2'd3
    } state_t;

    // Operand sum width: one carry bit above the wider operand.
    function automatic int sum_w(input int a_w, input int b_w);
        return ((a_w > b_w) ? a_w : b_w) + 1;
    endfunction

endpackage

// File: rtl/bus_sample_timer.sv
// Free-running sample counter; strobes cap_pt at each programmed capture point.
module bus_sample_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [CNT_W-1:0] sample_period,
    output logic             cap_pt
);

    logic [CNT_W-1:0] count;

    // Using >= rather than == lets a lowered period wrap the counter at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (!sample_en)
            count <= '0;
        else if (count >= sample_period)
            count <= '0;
        else
            count <= count + CNT_W'(1);
    end

    assign cap_pt = sample_en && (count == sample_period);

endmodule

// File: rtl/bidir_bus_port.sv
// Tri-state bus port: drives a registered a+b in DRIVE, samples the bus in LISTEN,
// with idle turnaround cycles between directions.
module bidir_bus_port
    import bidir_bus_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int A_W      = 4,
    parameter int B_W      = 2,
    parameter int CNT_W    = 8,
    parameter int TURN_CYC = 1
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             dir_req,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic             sample_en,
    input  logic [CNT_W-1:0] sample_period,
    output logic [WIDTH-1:0] cap_data,
    output logic             cap_valid,
    output logic             sample_miss,
    output logic             drive_active,
    output logic             turn_busy,
    output logic             sum_ovf
);

    localparam int SW   = sum_w(A_W, B_W);
    localparam int XW   = (SW > WIDTH) ? SW : WIDTH;
    localparam int TC_W = $clog2(TURN_CYC + 2);
    localparam logic [TC_W-1:0] TURN_LD = TC_W'(TURN_CYC);

    state_t           state, state_nxt;
    logic [TC_W-1:0]  tcnt, tcnt_nxt;
    logic [WIDTH-1:0] sum;
    logic [XW-1:0]    sum_x;
    logic             ovf_nxt;
    logic             cap_pt;

    // Sum is formed at XW bits so it can be both truncated and zero-extended.
    assign sum_x = XW'(a) + XW'(b);

    generate
        if (XW > WIDTH) begin : g_trunc
            assign ovf_nxt = |sum_x[XW-1:WIDTH];
        end else begin : g_fit
            assign ovf_nxt = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum     <= '0;
            sum_ovf <= 1'b0;
        end else begin
            sum     <= sum_x[WIDTH-1:0];
            sum_ovf <= ovf_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LISTEN;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        case (state)
            LISTEN: begin
                if (dir_req) begin
                    if (TURN_CYC == 0) begin
                        state_nxt = DRIVE;
                    end else begin
                        state_nxt = TURN_TX;
                        tcnt_nxt  = TURN_LD;
                    end
                end
            end
            TURN_TX: begin
                if (!dir_req) begin
                    state_nxt = LISTEN;
                    tcnt_nxt  = '0;
                end else if (tcnt <= TC_W'(1)) begin
                    state_nxt = DRIVE;
                    tcnt_nxt  = '0;
                end else begin
                    tcnt_nxt = tcnt - TC_W'(1);
                end
            end
            DRIVE: begin
                if (!dir_req) begin
                    if (TURN_CYC == 0) begin
                        state_nxt = LISTEN;
                    end else begin
                        state_nxt = TURN_RX;
                        tcnt_nxt  = TURN_LD;
                    end
                end
            end
            TURN_RX: begin
                // Release turnaround always runs to completion.
                if (tcnt <= TC_W'(1)) begin
                    state_nxt = LISTEN;
                    tcnt_nxt  = '0;
                end else begin
                    tcnt_nxt = tcnt - TC_W'(1);
                end
            end
            default: begin
                state_nxt = LISTEN;
                tcnt_nxt  = '0;
            end
        endcase
    end

    assign drive_active = (state == DRIVE);
    assign turn_busy    = (state == TURN_TX) || (state == TURN_RX);
    assign bus          = drive_active ? sum : {WIDTH{1'bz}};

    bus_sample_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .sample_en     (sample_en),
        .sample_period (sample_period),
        .cap_pt        (cap_pt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_data    <= '0;
            cap_valid   <= 1'b0;
            sample_miss <= 1'b0;
        end else begin
            cap_valid   <= cap_pt && (state == LISTEN);
            sample_miss <= cap_pt && (state != LISTEN);
            if (cap_pt && (state == LISTEN))
                cap_data <= bus;
        end
    end

endmodule

// File: doc/bidir_bus_port.md
Name: bidir_bus_port

Overview:
- Parametrised bidirectional bus port. Drives a registered operand sum onto a shared tri-state bus, or listens and periodically captures the bus value.
- Adds the following over the previous generation:
  - configurable data, operand and counter widths;
  - a programmable sample period;
  - a turnaround state machine, so the bus is never driven while direction is changing;
  - capture-valid, missed-sample and overflow indications.
- Sits at the chip-pad boundary between core logic and an external shared byte/word bus.

Parameters:
- WIDTH, 8, bus and capture data width
- A_W, 4, width of operand a
- B_W, 2, width of operand b
- CNT_W, 8, width of the sample counter and of sample_period
- TURN_CYC, 1, number of idle (Hi-Z) cycles inserted on each direction change; 0 is legal

Ports:
- clk  in  1  single clock, all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- bus  inout  WIDTH  shared tri-state bus
- dir_req  in  1  1 = request drive, 0 = request listen
- a  in  A_W  operand a
- b  in  B_W  operand b
- sample_en  in  1  enables the sample counter
- sample_period  in  CNT_W  capture occurs when count == sample_period
- cap_data  out  WIDTH  last captured bus value
- cap_valid  out  1  one-cycle pulse when cap_data updates
- sample_miss  out  1  one-cycle pulse when a capture point falls outside LISTEN
- drive_active  out  1  high exactly while bus is driven (state DRIVE)
- turn_busy  out  1  high in either turnaround state
- sum_ovf  out  1  registered; high when a+b exceeds WIDTH bits

Behaviour:
- Reset (async assert, sync release):
  - state = LISTEN, sum = 0, count = 0, turn counter = 0;
  - cap_data = 0, cap_valid = 0, sample_miss = 0, drive_active = 0, turn_busy = 0, sum_ovf = 0;
  - bus is Hi-Z.
- Reset asserted mid-drive releases the bus immediately (combinational from state).
- Sum path:
  - every cycle, sum <= a + b, computed at max(A_W,B_W)+1 bits;
  - zero-extended or truncated to WIDTH;
  - sum_ovf <= 1 if any truncated bit is nonzero.
- Bus drive rule: bus = sum when state == DRIVE, else all bits Z.
- FSM states: LISTEN, TURN_TX, DRIVE, TURN_RX.
  - LISTEN: if dir_req=1, go to TURN_TX and load the turn counter with TURN_CYC. If TURN_CYC=0, go directly to DRIVE.
  - TURN_TX: decrement the turn counter; at 1, go to DRIVE. If dir_req drops in TURN_TX, return to LISTEN next cycle; no drive occurs.
  - DRIVE: if dir_req=0, go to TURN_RX and load TURN_CYC. If TURN_CYC=0, go directly to LISTEN.
  - TURN_RX: count down to LISTEN. dir_req rising in TURN_RX is ignored until LISTEN is reached; the full turnaround always completes.
- Sample counter:
  - when sample_en=1: count <= (count >= sample_period) ? 0 : count+1, so the period is sample_period+1 cycles;
  - sample_period=0 captures every cycle;
  - sample_en=0 clears count to 0 and suppresses captures/misses;
  - sample_period lowered below count: count wraps to 0 next cycle, with no capture on that cycle.
- Capture point is sample_en && count == sample_period:
  - in LISTEN: cap_data <= bus, cap_valid=1 next cycle;
  - in any other state: cap_data holds, sample_miss=1 next cycle.
- Latency: bus to cap_data is 1 cycle; a/b to bus is 1 cycle once in DRIVE.

Decomposition:
- Package bidir_bus_pkg holds:
  - state enum (LISTEN, TURN_TX, DRIVE, TURN_RX);
  - localparam function for the sum width max(A_W,B_W)+1.
- One sub-module, bus_sample_timer, containing the counter, period compare and capture-point strobe.
- FSM, sum and tri-state logic stay in the top level.

Test Plan:
- Reset held, dir_req=1, a=15, b=3 -> bus all Z, all outputs 0; after release, TURN_TX for 1 cycle, then DRIVE, bus=8'h12, drive_active=1.
- LISTEN, sample_en=1, sample_period=50, external driver puts 8'hA5 on bus -> cap_valid pulses every 51 cycles, cap_data=8'hA5.
- Capture point reached while in DRIVE -> sample_miss=1 for one cycle, cap_data unchanged, cap_valid=0.
- TURN_CYC=3, dir_req pulsed 1 for 2 cycles -> TURN_TX then LISTEN, bus never driven, drive_active never high.
- WIDTH=4, a=15, b=3 -> bus=4'h2 in DRIVE, sum_ovf=1. With a=5, b=2 -> bus=4'h7, sum_ovf=0.
- Reset asserted mid-DRIVE -> bus Z in the same cycle, state LISTEN, count=0, cap_data=0.
